// File: rtl/qpu_ifu_dynbpu.sv
// Dynamic branch predictor: a tagless, direct-mapped table of 2-bit counters with a static fallback and a registered training stage.
// Optional macro QPU_BPU_BYPASS_EN lets lookups see the pending write one cycle earlier.
module qpu_ifu_dynbpu #(
  parameter int PC_SIZE   = 32,
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_LSB   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_SIZE-1:0] pc,
  input  logic               dec_bxx,
  input  logic [XLEN-1:0]    dec_bjp_imm,
  output logic               prdt_taken,
  output logic               prdt_hit,
  output logic [PC_SIZE-1:0] prdt_pc_add_op1,
  output logic [PC_SIZE-1:0] prdt_pc_add_op2,
  input  logic               upd_vld,
  input  logic [PC_SIZE-1:0] upd_pc,
  input  logic               upd_taken,
  input  logic               bht_clr
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic             vld_q [BHT_DEPTH];
  logic             vld_d [BHT_DEPTH];
  logic [1:0]       cnt_q [BHT_DEPTH];
  logic [1:0]       cnt_d [BHT_DEPTH];
  logic             wr_vld_q, wr_vld_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]       wr_cnt_q, wr_cnt_d;

  logic [IDX_W-1:0] ri, ui;
  logic             look_vld;
  logic [1:0]       look_cnt;
  logic             upd_fwd, cur_vld;
  logic [1:0]       cur_cnt, nxt_cnt;
  logic             unused_upd_pc;

  assign ri            = pc[IDX_LSB +: IDX_W];
  assign ui            = upd_pc[IDX_LSB +: IDX_W];
  assign unused_upd_pc = ^upd_pc;

`ifdef QPU_BPU_BYPASS_EN
  logic look_byp;
  assign look_byp = wr_vld_q && (wr_idx_q == ri);
  assign look_vld = look_byp | vld_q[ri];
  assign look_cnt = look_byp ? wr_cnt_q : cnt_q[ri];
`else
  assign look_vld = vld_q[ri];
  assign look_cnt = cnt_q[ri];
`endif

  assign prdt_hit        = dec_bxx & look_vld;
  assign prdt_taken      = dec_bxx & (look_vld ? look_cnt[1] : dec_bjp_imm[XLEN-1]);
  assign prdt_pc_add_op1 = pc;
  assign prdt_pc_add_op2 = dec_bjp_imm[PC_SIZE-1:0];

  // Training stage 1: forward the in-flight write so back-to-back updates stay exact.
  always_comb begin
    upd_fwd = wr_vld_q && (wr_idx_q == ui);
    cur_vld = upd_fwd | vld_q[ui];
    cur_cnt = upd_fwd ? wr_cnt_q : cnt_q[ui];
    nxt_cnt = cur_cnt;
    if (!cur_vld) begin
      nxt_cnt = upd_taken ? 2'b10 : 2'b01;
    end else if (upd_taken) begin
      nxt_cnt = (cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'd1;
    end else begin
      nxt_cnt = (cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'd1;
    end
    wr_vld_d = upd_vld & ~bht_clr;
    wr_idx_d = upd_vld ? ui : wr_idx_q;
    wr_cnt_d = upd_vld ? nxt_cnt : wr_cnt_q;
  end

  // Training stage 2: commit the pending write; a clear wins over it.
  always_comb begin
    for (int i = 0; i < BHT_DEPTH; i++) begin
      vld_d[i] = vld_q[i];
      cnt_d[i] = cnt_q[i];
      if (bht_clr) begin
        vld_d[i] = 1'b0;
      end else if (wr_vld_q && (wr_idx_q == IDX_W'(i))) begin
        vld_d[i] = 1'b1;
        cnt_d[i] = wr_cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        cnt_q[i] <= 2'b01;
      end
      wr_vld_q <= 1'b0;
      wr_idx_q <= '0;
      wr_cnt_q <= 2'b01;
    end else begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        vld_q[i] <= vld_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      wr_vld_q <= wr_vld_d;
      wr_idx_q <= wr_idx_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

endmodule

// File: tb/tb_qpu_ifu_dynbpu.sv
// Scoreboard bench for qpu_ifu_dynbpu: a table-of-integers model predicts every cycle's lookup, a monitor compares.
module tb_qpu_ifu_dynbpu;
  localparam int PC_SIZE = 32;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 64;
  localparam int IDX_LSB = 2;
`ifdef QPU_BPU_BYPASS_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 2;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PC_SIZE-1:0] pc = '0;
  logic               dec_bxx = 1'b0;
  logic [XLEN-1:0]    dec_bjp_imm = '0;
  logic               prdt_taken, prdt_hit;
  logic [PC_SIZE-1:0] prdt_pc_add_op1, prdt_pc_add_op2;
  logic               upd_vld = 1'b0;
  logic [PC_SIZE-1:0] upd_pc = '0;
  logic               upd_taken = 1'b0;
  logic               bht_clr = 1'b0;

  qpu_ifu_dynbpu #(.PC_SIZE(PC_SIZE), .XLEN(XLEN), .BHT_DEPTH(DEPTH), .IDX_LSB(IDX_LSB)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .dec_bxx(dec_bxx), .dec_bjp_imm(dec_bjp_imm),
    .prdt_taken(prdt_taken), .prdt_hit(prdt_hit),
    .prdt_pc_add_op1(prdt_pc_add_op1), .prdt_pc_add_op2(prdt_pc_add_op2),
    .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_taken(upd_taken), .bht_clr(bht_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [31:0] pc;
    logic       taken;
    logic       hit;
    logic [31:0] op1;
    logic [31:0] op2;
  } exp_t;

  typedef struct {
    int idx;
    int cnt;
    int due;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];
  bit    vis_v[DEPTH];
  int    vis_c[DEPTH];
  bit    log_v[DEPTH];
  int    log_c[DEPTH];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> IDX_LSB) % DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      vis_v[i] = 1'b0; vis_c[i] = 1;
      log_v[i] = 1'b0; log_c[i] = 1;
    end
    pend_q.delete();
  endtask

  // End-of-cycle model update: counters evolve immediately in log_*, become visible LAG cycles later in vis_*.
  task automatic model_edge(bit upd, logic [31:0] upc, bit tk, bit clr);
    int i;
    int n;
    if (rst_n) begin
      if (clr) begin
        for (int k = 0; k < DEPTH; k++) begin
          vis_v[k] = 1'b0;
          log_v[k] = 1'b0;
        end
        pend_q.delete();
      end else begin
        if (upd) begin
          i = idx_of(upc);
          if (!log_v[i]) n = tk ? 2 : 1;
          else if (tk)   n = (log_c[i] < 3) ? log_c[i] + 1 : 3;
          else           n = (log_c[i] > 0) ? log_c[i] - 1 : 0;
          log_v[i] = 1'b1;
          log_c[i] = n;
          pend_q.push_back('{idx: i, cnt: n, due: cyc + LAG});
        end
        while (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
          vis_v[pend_q[0].idx] = 1'b1;
          vis_c[pend_q[0].idx] = pend_q[0].cnt;
          void'(pend_q.pop_front());
        end
      end
    end
    cyc++;
  endtask

  // One clock cycle: drive inputs, push the expected lookup, then advance the model at the edge.
  task automatic step(bit bxx, logic [31:0] p, logic [31:0] imm, bit upd, logic [31:0] upc, bit tk, bit clr);
    exp_t e;
    int   i;
    pc = p; dec_bxx = bxx; dec_bjp_imm = imm;
    upd_vld = upd; upd_pc = upc; upd_taken = tk; bht_clr = clr;
    i = idx_of(p);
    e.cyc   = cyc;
    e.pc    = p;
    e.hit   = bxx & vis_v[i];
    e.taken = bxx & (vis_v[i] ? (vis_c[i] >= 2) : imm[31]);
    e.op1   = p;
    e.op2   = imm;
    exp_q.push_back(e);
    @(posedge clk);
    model_edge(upd, upc, tk, clr);
    #1;
  endtask

  task automatic look(logic [31:0] p, logic [31:0] imm);
    step(1'b1, p, imm, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv, int c);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, c, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("cyc=%0d pc=%h bxx=%b taken=%b hit=%b", e.cyc, e.pc, dec_bxx, prdt_taken, prdt_hit);
        chk("prdt_taken", {31'b0, prdt_taken}, {31'b0, e.taken}, e.cyc);
        chk("prdt_hit",   {31'b0, prdt_hit},   {31'b0, e.hit},   e.cyc);
        chk("pc_add_op1", prdt_pc_add_op1, e.op1, e.cyc);
        chk("pc_add_op2", prdt_pc_add_op2, e.op2, e.cyc);
      end
    end
  end

  localparam logic [31:0] NEG8 = 32'hFFFF_FFF8;
  localparam logic [31:0] POS8 = 32'h0000_0008;

  initial begin : stim
    logic [31:0] rp, ri, rimm;
    int drain;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // static fallback after reset
    look(32'h40, NEG8);
    look(32'h40, POS8);
    step(1'b0, 32'h40, NEG8, 1'b0, 32'h0, 1'b0, 1'b0);

    // first training of an entry, then two taken updates
    step(1'b1, 32'h40, NEG8, 1'b1, 32'h40, 1'b0, 1'b0);
    repeat (3) look(32'h40, NEG8);
    step(1'b1, 32'h40, NEG8, 1'b1, 32'h40, 1'b1, 1'b0);
    step(1'b1, 32'h40, NEG8, 1'b1, 32'h40, 1'b1, 1'b0);
    repeat (3) look(32'h40, NEG8);

    // back-to-back saturation both ways
    repeat (4) step(1'b1, 32'h80, POS8, 1'b1, 32'h80, 1'b1, 1'b0);
    repeat (2) look(32'h80, POS8);
    repeat (5) step(1'b1, 32'h80, NEG8, 1'b1, 32'h80, 1'b0, 1'b0);
    repeat (3) look(32'h80, NEG8);

    // aliasing: 0x140 shares the entry of 0x40
    repeat (2) step(1'b1, 32'h140, POS8, 1'b1, 32'h40, 1'b1, 1'b0);
    repeat (3) look(32'h140, POS8);

    // clear with a pending write and a simultaneous update
    step(1'b1, 32'h44, POS8, 1'b1, 32'h44, 1'b1, 1'b0);
    step(1'b1, 32'h40, POS8, 1'b1, 32'h80, 1'b1, 1'b1);
    look(32'h40, NEG8); look(32'h80, POS8); look(32'h44, NEG8);
    repeat (2) look(32'h44, POS8);

    // update visibility latency
    step(1'b1, 32'h48, POS8, 1'b1, 32'h48, 1'b1, 1'b0);
    repeat (3) look(32'h48, POS8);

    // reset asserted while a write is pending
    step(1'b1, 32'h40, POS8, 1'b1, 32'h40, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) look(32'h40, NEG8);
    rst_n = 1'b1;
    repeat (3) look(32'h40, POS8);

    // randomized traffic over 8 hot entries with aliasing upper bits
    for (int n = 0; n < 600; n++) begin
      rp   = ($urandom & 32'hFFFF_FE03) | (32'($urandom_range(0, 7)) << 2);
      ri   = ($urandom & 32'hFFFF_FE03) | (32'($urandom_range(0, 7)) << 2);
      rimm = $urandom;
      step(($urandom_range(0, 4) != 0), rp, rimm, $urandom_range(0, 1) == 1, ri,
           $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
